load_data_align_32: RTL and testbench

LOAD_DATA_ALIGN_32 -- requirements
Module: load_data_align_32

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/read_data_extract_32.sv | 51 +++++
 rtl/load_data_align_32.sv | 127 ++++++++++++
 tb/tb_load_data_align_32.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared load/store encodings: load types, store-style byte-lane masks and the
// load-unit FSM state encoding, plus the access legality check.
package mem_pkg;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } ld_type_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } ld_state_e;

   // Byte-lane masks: bit3 covers data bits 31:24, bit0 covers 7:0.
   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_B0   = 4'b0001;
   localparam logic [3:0] MASK_H_LO = 4'b0011;
   localparam logic [3:0] MASK_H_HI = 4'b1100;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   // High for a misaligned half/word or an undefined load type.
   function automatic logic ld_access_err(input logic [1:0] addr_lo,
                                          input logic [2:0] ld_type);
      logic err;
      case (ld_type)
         LD_LB, LD_LBU: err = 1'b0;
         LD_LH, LD_LHU: err = addr_lo[0];
         LD_LW:         err = (addr_lo != 2'b00);
         default:       err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/read_data_extract_32.sv
// Combinational lane select and sign/zero extension of a raw read word,
// with the matching byte-lane mask.
module read_data_extract_32
   import mem_pkg::*;
(
   input  logic [1:0]  addr_i,
   input  logic [2:0]  type_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o,
   output logic [3:0]  mask_o
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Little-endian: lowest address maps to the lowest-numbered bits.
   assign lane_byte = word_i[{addr_i, 3'b000} +: 8];
   assign lane_half = addr_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      data_o = 32'h0;
      mask_o = MASK_NONE;
      case (type_i)
         LD_LB: begin
            data_o = {{24{lane_byte[7]}}, lane_byte};
            mask_o = MASK_B0 << addr_i;
         end
         LD_LBU: begin
            data_o = {24'h0, lane_byte};
            mask_o = MASK_B0 << addr_i;
         end
         LD_LH: begin
            data_o = {{16{lane_half[15]}}, lane_half};
            mask_o = addr_i[1] ? MASK_H_HI : MASK_H_LO;
         end
         LD_LHU: begin
            data_o = {16'h0, lane_half};
            mask_o = addr_i[1] ? MASK_H_HI : MASK_H_LO;
         end
         LD_LW: begin
            data_o = word_i;
            mask_o = MASK_WORD;
         end
         default: begin
            data_o = 32'h0;
            mask_o = MASK_NONE;
         end
      endcase
   end

endmodule

// File: rtl/load_data_align_32.sv
// Single-outstanding load unit: accepts a load, issues one word read, and
// returns the aligned/extended result through a valid/ready response port.
module load_data_align_32
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_type,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [3:0]  rsp_mask,
   output ld_state_e   dbg_state
);

   // Handshakes: a load transfers on a rising edge with ld_valid && ld_ready;
   // a response transfers on a rising edge with rsp_valid && rsp_ready, and
   // rsp_* hold steady while rsp_valid is high and rsp_ready is low.

   ld_state_e   state_q;
   logic [1:0]  addr_q;
   logic [2:0]  type_q;
   logic        kill_q;
   logic        mem_req_q;
   logic [31:0] mem_addr_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_data_q;
   logic [3:0]  rsp_mask_q;

   logic [31:0] ext_data_d;
   logic [3:0]  ext_mask_d;

   read_data_extract_32 u_extract (
      .addr_i (addr_q),
      .type_i (type_q),
      .word_i (mem_rdata),
      .data_o (ext_data_d),
      .mask_o (ext_mask_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= 2'b00;
         type_q      <= 3'b000;
         kill_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 32'h0;
         rsp_mask_q  <= MASK_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               // flush takes priority over a simultaneous request
               if (ld_valid && !flush) begin
                  addr_q <= ld_addr[1:0];
                  type_q <= ld_type;
                  if (ld_access_err(ld_addr[1:0], ld_type)) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= 32'h0;
                     rsp_mask_q  <= MASK_NONE;
                  end else begin
                     state_q    <= S_REQ;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {ld_addr[31:2], 2'b00};
                  end
               end
            end
            S_REQ: begin
               mem_req_q <= 1'b0;
               state_q   <= flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
               if (flush) kill_q <= 1'b1;
               // A killed read still has to drain its ack before reuse.
               if (mem_ack) begin
                  kill_q <= 1'b0;
                  if (kill_q || flush) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= ext_data_d;
                     rsp_mask_q  <= ext_mask_d;
                  end
               end
            end
            S_RESP: begin
               if (flush || rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               mem_req_q   <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready  = (state_q == S_IDLE);
   assign mem_req   = mem_req_q && !flush;
   assign mem_addr  = mem_addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_mask  = rsp_mask_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_load_data_align_32.sv
// Directed bench for load_data_align_32 with hand-computed expectations.
module tb_load_data_align_32;
   import mem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [2:0]  ld_type;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [3:0]  rsp_mask;
   ld_state_e   dbg_state;

   int checks = 0;
   int errors = 0;

   load_data_align_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_addr   (ld_addr),
      .ld_type   (ld_type),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_mask  (rsp_mask),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [31:0] a, input logic [2:0] t);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_type  = t;
      step();
      ld_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_type = 3'b000;
      flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; rsp_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst_ready", 32'(ld_ready), 32'd1);
      chk("rst_req",   32'(mem_req), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data",  rsp_data, 32'h0);
      chk("rst_mask",  32'(rsp_mask), 32'h0);
      chk("rst_addr",  mem_addr, 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

      // LB 0x103, word 0x80FF_1234 -> byte 0x80 sign-extended
      accept(32'h0000_0103, 3'b000);
      chk("lb_req",   32'(mem_req), 32'd1);
      chk("lb_addr",  mem_addr, 32'h0000_0100);
      chk("lb_ready", 32'(ld_ready), 32'd0);
      step();
      chk("lb_req_one", 32'(mem_req), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
      step();
      mem_ack = 1'b0;
      chk("lb_valid", 32'(rsp_valid), 32'd1);
      chk("lb_data",  rsp_data, 32'hFFFF_FF80);
      chk("lb_mask",  32'(rsp_mask), 32'b1000);
      chk("lb_err",   32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("lb_done", 32'(rsp_valid), 32'd0);
      chk("lb_idle", 32'(ld_ready), 32'd1);

      // LHU 0x102, word 0x8001_7FFF -> upper half zero-extended
      accept(32'h0000_0102, 3'b101);
      chk("lhu_addr", mem_addr, 32'h0000_0100);
      step();
      mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
      step();
      mem_ack = 1'b0;
      chk("lhu_data", rsp_data, 32'h0000_8001);
      chk("lhu_mask", 32'(rsp_mask), 32'b1100);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

      // LW 0x101 misaligned: error response one cycle after accept
      accept(32'h0000_0101, 3'b010);
      chk("lwmis_req",   32'(mem_req), 32'd0);
      chk("lwmis_valid", 32'(rsp_valid), 32'd1);
      chk("lwmis_err",   32'(rsp_err), 32'd1);
      chk("lwmis_mask",  32'(rsp_mask), 32'b0000);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      chk("lwmis_idle", 32'(ld_ready), 32'd1);

      // illegal type code 011
      accept(32'h0000_0000, 3'b011);
      chk("ill_err",   32'(rsp_err), 32'd1);
      chk("ill_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

      // LW 0x200, flush in WAIT, ack three cycles later -> no response
      accept(32'h0000_0200, 3'b010);
      chk("fw_addr", mem_addr, 32'h0000_0200);
      step();
      flush = 1'b1; step(); flush = 1'b0;
      chk("fw_state1", 32'(dbg_state), 32'(S_WAIT));
      step(); step();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 1'b0;
      chk("fw_valid", 32'(rsp_valid), 32'd0);
      chk("fw_ready", 32'(ld_ready), 32'd1);
      step();
      chk("fw_valid2", 32'(rsp_valid), 32'd0);

      // LH 0x0, word 0x1234_F00D -> 0xFFFF_F00D held while rsp_ready low
      accept(32'h0000_0000, 3'b001);
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1234_F00D;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      held = 32'hFFFF_F00D;
      for (int i = 0; i < 5; i++) begin
         chk("lh_valid", 32'(rsp_valid), 32'd1);
         chk("lh_data",  rsp_data, held);
         chk("lh_ready", 32'(ld_ready), 32'd0);
         step();
      end
      chk("lh_mask", 32'(rsp_mask), 32'b0011);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      chk("lh_done", 32'(rsp_valid), 32'd0);

      // flush together with ld_valid in IDLE: request ignored
      flush = 1'b1;
      accept(32'h0000_0010, 3'b000);
      flush = 1'b0;
      chk("fi_state", 32'(dbg_state), 32'(S_IDLE));
      chk("fi_req",   32'(mem_req), 32'd0);

      // flush in REQ suppresses mem_req and returns to IDLE
      accept(32'h0000_0101, 3'b100);
      flush = 1'b1;
      #1;
      chk("fr_req", 32'(mem_req), 32'd0);
      step();
      flush = 1'b0;
      chk("fr_state", 32'(dbg_state), 32'(S_IDLE));

      // LBU 0x101, word 0x0000_AB00, then flush in RESP
      accept(32'h0000_0101, 3'b100);
      step();
      mem_ack = 1'b1; mem_rdata = 32'h0000_AB00;
      step();
      mem_ack = 1'b0;
      chk("lbu_data", rsp_data, 32'h0000_00AB);
      chk("lbu_mask", 32'(rsp_mask), 32'b0010);
      flush = 1'b1; step(); flush = 1'b0;
      chk("fresp_valid", 32'(rsp_valid), 32'd0);
      chk("fresp_state", 32'(dbg_state), 32'(S_IDLE));

      // stray ack in IDLE
      mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_ack = 1'b0;
      chk("stray_valid", 32'(rsp_valid), 32'd0);
      chk("stray_state", 32'(dbg_state), 32'(S_IDLE));

      // reset in WAIT, then a late ack
      accept(32'h0000_0300, 3'b010);
      step();
      chk("rw_state", 32'(dbg_state), 32'(S_WAIT));
      rst_n = 1'b0;
      #1;
      chk("rw_async_state", 32'(dbg_state), 32'(S_IDLE));
      chk("rw_async_addr",  mem_addr, 32'h0);
      #1;
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
      step();
      mem_ack = 1'b0;
      chk("rw_state2", 32'(dbg_state), 32'(S_IDLE));
      chk("rw_valid",  32'(rsp_valid), 32'd0);
      chk("rw_data",   rsp_data, 32'h0);
      chk("rw_mask",   32'(rsp_mask), 32'h0);
      chk("rw_req",    32'(mem_req), 32'd0);
      chk("rw_ready",  32'(ld_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
